clp_inst_dispatch: RTL and testbench

CLP_INST_DISPATCH -- requirements
Module: clp_inst_dispatch

---
 rtl/clp_inst_dispatch_pkg.sv | 34 +++
 rtl/clp_inst_dispatch_inst_ram.sv | 45 ++++
 rtl/clp_inst_dispatch.sv | 181 ++++++++++++++++++
 tb/tb_clp_inst_dispatch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clp_inst_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clp_inst_dispatch_pkg
// Description : Shared constants, FSM state encoding and opcode helper for
//               the CLP instruction dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package clp_inst_dispatch_pkg;

    // Default geometry of the instruction store and the controller handshake.
    localparam int c_inst_width_dflt  = 100;
    localparam int c_depth_dflt       = 64;
    localparam int c_ack_timeout_dflt = 8;

    // Low nibble of an instruction word that terminates a program.
    localparam logic [3:0] c_end_opcode = 4'hF;

    // Dispatcher sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    // True when the opcode nibble marks the end of the stored program.
    function automatic logic is_end_op(input logic [3:0] opcode);
        return (opcode == c_end_opcode);
    endfunction

endpackage : clp_inst_dispatch_pkg
`default_nettype wire

// File: rtl/clp_inst_dispatch_inst_ram.sv
`default_nettype none
// ============================================================================
// Module      : clp_inst_dispatch_inst_ram
// Description : Instruction store. One write port, one registered read port.
//               Contents are deliberately not reset so a loaded program
//               survives a dispatcher reset.
// Revision    : 1.0 - initial release
// ============================================================================
module clp_inst_dispatch_inst_ram
    import clp_inst_dispatch_pkg::*;
#(
    parameter int WIDTH      = c_inst_width_dflt,
    parameter int DEPTH      = c_depth_dflt,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Loader write port; the array has no reset on purpose.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; the output holds its value between read enables.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : clp_inst_dispatch_inst_ram
`default_nettype wire

// File: rtl/clp_inst_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : clp_inst_dispatch
// Description : Walks a stored program of layer instructions, launching each
//               one on the CLP controller and waiting for it to complete.
//               An END opcode, the last store entry or a missing
//               acknowledge ends the run.
// Revision    : 1.0 - initial release
// ============================================================================
module clp_inst_dispatch
    import clp_inst_dispatch_pkg::*;
#(
    parameter int  INST_WIDTH  = c_inst_width_dflt,
    parameter int  DEPTH       = c_depth_dflt,
    parameter int  ACK_TIMEOUT = c_ack_timeout_dflt,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  inst_wr_en,
    input  logic [ADDR_WIDTH-1:0] inst_wr_addr,
    input  logic [INST_WIDTH-1:0] inst_wr_data,
    input  logic                  clp_state,
    output logic                  clp_enable,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] pc
);

    // The acknowledge window counts the enable cycle itself, so the counter
    // must be able to hold ACK_TIMEOUT.
    localparam int                    CNT_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      c_ack_last = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_pc_last  = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  r_error;
    logic                  w_error_nxt;
    logic [CNT_W-1:0]      r_ack_cnt;
    logic [CNT_W-1:0]      w_ack_cnt_nxt;
    logic [INST_WIDTH-1:0] r_instruction;
    logic [INST_WIDTH-1:0] w_instr_nxt;
    logic [INST_WIDTH-1:0] w_rd_data;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_is_end;
    logic                  w_clp_enable;
    logic                  w_done;

    // Loads are only accepted while idle so a running program never changes.
    assign w_wr_en  = inst_wr_en && (r_state == ST_IDLE);
    assign w_is_end = is_end_op(w_rd_data[3:0]);

    clp_inst_dispatch_inst_ram #(
        .WIDTH      (INST_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_inst_ram (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (inst_wr_addr),
        .i_wr_data  (inst_wr_data),
        .i_rd_en    (w_rd_en),
        .i_rd_addr  (r_pc),
        .o_rd_data  (w_rd_data)
    );

    // State register; reset abandons any run in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_error_nxt   = r_error;
        w_ack_cnt_nxt = r_ack_cnt;
        w_instr_nxt   = r_instruction;
        w_rd_en       = 1'b0;
        w_clp_enable  = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_error_nxt = 1'b0;
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                w_rd_en     = 1'b1;
                w_state_nxt = ST_ISSUE;
            end

            ST_ISSUE: begin
                w_instr_nxt = w_rd_data;
                if (w_is_end) begin
                    w_state_nxt = ST_FINISH;
                end else if (!clp_state) begin
                    // Never launch onto a controller that still reports busy;
                    // hold here until it is free.
                    w_clp_enable  = 1'b1;
                    w_ack_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                if (clp_state) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_ack_cnt >= c_ack_last) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_ack_cnt_nxt = r_ack_cnt + CNT_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!clp_state) begin
                    // The last store entry ends the run; the pc never wraps.
                    if (r_pc == c_pc_last) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_pc_nxt    = r_pc + ADDR_WIDTH'(1);
                        w_state_nxt = ST_FETCH;
                    end
                end
            end

            ST_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Program counter, sticky error, acknowledge counter and held instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_error       <= 1'b0;
            r_ack_cnt     <= '0;
            r_instruction <= '0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_error       <= w_error_nxt;
            r_ack_cnt     <= w_ack_cnt_nxt;
            r_instruction <= w_instr_nxt;
        end
    end

    // During ISSUE the store's registered read data is already the word being
    // launched, so it is shown directly; afterwards the held copy keeps the
    // output stable until the next ISSUE.
    assign instruction = (r_state == ST_ISSUE) ? w_rd_data : r_instruction;
    assign clp_enable  = w_clp_enable;
    assign done        = w_done;
    assign busy        = (r_state != ST_IDLE);
    assign error       = r_error;
    assign pc          = r_pc;

endmodule : clp_inst_dispatch
`default_nettype wire

// File: tb/tb_clp_inst_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_clp_inst_dispatch
// Description : Directed, table-driven bench for clp_inst_dispatch with a
//               behavioural CLP controller model and a shadow program store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clp_inst_dispatch;

    localparam int IW = 100;
    localparam int DP = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          inst_wr_en;
    logic [AW-1:0] inst_wr_addr;
    logic [IW-1:0] inst_wr_data;
    logic          clp_state;
    logic          clp_enable;
    logic [IW-1:0] instruction;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] pc;

    always #5 clk = ~clk;

    clp_inst_dispatch #(
        .INST_WIDTH  (IW),
        .DEPTH       (DP),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .inst_wr_en   (inst_wr_en),
        .inst_wr_addr (inst_wr_addr),
        .inst_wr_data (inst_wr_data),
        .clp_state    (clp_state),
        .clp_enable   (clp_enable),
        .instruction  (instruction),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .pc           (pc)
    );

    int checks   = 0;
    int failures = 0;

    // Shadow copy of what the bench believes the store holds.
    logic [IW-1:0] shadow [DP];

    // CLP controller model: busy for m_blen cycles starting the cycle after
    // an enable, or never acknowledging when m_ack is clear.
    int m_cnt   = 0;
    bit m_ack   = 1'b0;
    int m_blen  = 0;
    bit prev_en = 1'b0;

    // Outputs sampled once per cycle.
    logic          s_en, s_busy, s_done, s_error;
    logic [IW-1:0] s_instr;
    logic [AW-1:0] s_pc;

    // Per-run observations.
    int r_en, r_done, r_lat, r_pc_done, r_pc_bad, r_ins_bad, r_stab_bad, r_ovl;
    bit r_err_done, r_err_start, r_err_idle, r_busy_idle, r_tmo;

    typedef struct {
        int n_layers;
        bit has_end;
        bit ack;
        int blen;
        bit wr0;
        bit disturb;
        int exp_en;
        int exp_lat;
        bit exp_err;
        int exp_pc_done;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_word(input int id, input int i);
        return {32'(id) + 32'h5A00_0000, 32'(i * 7 + 3), 32'hC0DE_0000 + 32'(i), 4'(i % 15)};
    endfunction

    function automatic logic [IW-1:0] end_word(input int id);
        return {32'hDEAD_BEEF, 32'(id), 32'h0, 4'hF};
    endfunction

    // One clock: advance the controller model, then sample the DUT.
    task automatic step();
        @(posedge clk);
        #1;
        if (prev_en && m_ack) m_cnt = m_blen;
        clp_state = (m_cnt > 0);
        if (m_cnt > 0) m_cnt--;
        #1;
        s_en    = clp_enable;
        s_busy  = busy;
        s_done  = done;
        s_error = error;
        s_instr = instruction;
        s_pc    = pc;
        prev_en = clp_enable;
    endtask

    task automatic write_word(input int addr, input logic [IW-1:0] data);
        inst_wr_en   = 1'b1;
        inst_wr_addr = AW'(addr);
        inst_wr_data = data;
        step();
        inst_wr_en   = 1'b0;
    endtask

    task automatic load(input int id, input int n, input bit has_end, input bit skip0);
        for (int i = 0; i < n; i++) begin
            shadow[i] = mk_word(id, i);
            if (!(skip0 && i == 0)) write_word(i, shadow[i]);
        end
        if (has_end) begin
            shadow[n] = end_word(id);
            write_word(n, shadow[n]);
        end
    endtask

    task automatic run(input bit ack, input int blen, input bit wr0, input bit disturb);
        logic [IW-1:0] held;
        int n;
        r_en = 0; r_done = 0; r_lat = -1; r_pc_done = -1;
        r_pc_bad = 0; r_ins_bad = 0; r_stab_bad = 0; r_ovl = 0;
        r_err_done = 1'b0; r_tmo = 1'b0;
        held = '0;
        m_ack = ack; m_blen = blen; m_cnt = 0; prev_en = 1'b0;
        start = 1'b1;
        if (wr0) begin
            inst_wr_en   = 1'b1;
            inst_wr_addr = '0;
            inst_wr_data = shadow[0];
        end
        step();
        start = 1'b0; inst_wr_en = 1'b0;
        n = 1;
        r_err_start = s_error;
        while (1'b1) begin
            if (s_en) begin
                if (int'(s_pc) != r_en) r_pc_bad++;
                if (s_instr !== shadow[s_pc]) r_ins_bad++;
                if (clp_state) r_ovl++;
                held = s_instr;
                r_en++;
            end else if (clp_state && r_en > 0 && s_instr !== held) begin
                r_stab_bad++;
            end
            if (s_done) begin
                r_done++;
                r_lat      = n;
                r_err_done = s_error;
                r_pc_done  = int'(s_pc);
                break;
            end
            if (n >= 5000) begin
                r_tmo = 1'b1;
                break;
            end
            if (disturb && n == 6) begin
                start        = 1'b1;
                inst_wr_en   = 1'b1;
                inst_wr_addr = AW'(1);
                inst_wr_data = end_word(99);
            end
            step();
            start = 1'b0; inst_wr_en = 1'b0;
            n++;
        end
        repeat (2) begin
            step();
            if (s_done) r_done++;
        end
        r_busy_idle = s_busy;
        r_err_idle  = s_error;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        int bs;
        // {layers, has_end, ack, blen, wr0, disturb, exp_en, exp_lat, exp_err, exp_pc_done}
        vecs[0] = '{3,  1'b1, 1'b1, 790, 1'b0, 1'b1, 3,  2382, 1'b0, 3};
        vecs[1] = '{0,  1'b1, 1'b1, 4,   1'b0, 1'b0, 0,  3,    1'b0, 0};
        vecs[2] = '{1,  1'b1, 1'b0, 0,   1'b0, 1'b0, 1,  10,   1'b1, 0};
        vecs[3] = '{3,  1'b1, 1'b1, 1,   1'b0, 1'b0, 3,  15,   1'b0, 3};
        vecs[4] = '{64, 1'b0, 1'b1, 1,   1'b0, 1'b0, 64, 257,  1'b0, 63};
        vecs[5] = '{2,  1'b1, 1'b1, 5,   1'b0, 1'b1, 2,  19,   1'b0, 2};
        vecs[6] = '{1,  1'b1, 1'b1, 2,   1'b1, 1'b0, 1,  8,    1'b0, 1};

        rst_n = 1'b0; start = 1'b0; inst_wr_en = 1'b0;
        inst_wr_addr = '0; inst_wr_data = '0; clp_state = 1'b0;
        repeat (3) step();
        chk("reset_clp_enable", s_en, 0);
        chk("reset_instruction_zero", (s_instr == '0), 1);
        chk("reset_busy", s_busy, 0);
        chk("reset_done", s_done, 0);
        chk("reset_error", s_error, 0);
        chk("reset_pc", s_pc, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            load(i, vecs[i].n_layers, vecs[i].has_end, vecs[i].wr0);
            run(vecs[i].ack, vecs[i].blen, vecs[i].wr0, vecs[i].disturb);
            chk($sformatf("v%0d_run_bound", i), r_tmo, 0);
            chk($sformatf("v%0d_enables", i), r_en, vecs[i].exp_en);
            chk($sformatf("v%0d_done_count", i), r_done, 1);
            chk($sformatf("v%0d_done_latency", i), r_lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_error_at_done", i), r_err_done, vecs[i].exp_err);
            chk($sformatf("v%0d_error_after_start", i), r_err_start, 0);
            chk($sformatf("v%0d_error_sticky_idle", i), r_err_idle, vecs[i].exp_err);
            chk($sformatf("v%0d_pc_at_done", i), r_pc_done, vecs[i].exp_pc_done);
            chk($sformatf("v%0d_pc_sequence_bad", i), r_pc_bad, 0);
            chk($sformatf("v%0d_instr_at_enable_bad", i), r_ins_bad, 0);
            chk($sformatf("v%0d_instr_stable_bad", i), r_stab_bad, 0);
            chk($sformatf("v%0d_enable_while_clp_busy", i), r_ovl, 0);
            chk($sformatf("v%0d_busy_after_done", i), r_busy_idle, 0);
        end

        // Reset in the middle of the second layer's WAIT_DONE.
        load(7, 3, 1'b1, 1'b0);
        m_ack = 1'b1; m_blen = 3; m_cnt = 0; prev_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("midrun_busy_before_reset", s_busy, 1);
        chk("midrun_clp_state_before_reset", clp_state, 1);
        chk("midrun_pc_before_reset", s_pc, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrun_reset_clp_enable", s_en, 0);
        chk("midrun_reset_instruction_zero", (s_instr == '0), 1);
        chk("midrun_reset_busy", s_busy, 0);
        chk("midrun_reset_done", s_done, 0);
        chk("midrun_reset_error", s_error, 0);
        chk("midrun_reset_pc", s_pc, 0);
        dn = 0; bs = 0;
        repeat (5) begin
            step();
            if (s_done) dn++;
            if (s_busy) bs++;
        end
        chk("midrun_no_done_after_reset", dn, 0);
        chk("midrun_idle_after_reset", bs, 0);

        // Fresh start must rerun the intact program from pc 0.
        run(1'b1, 1, 1'b0, 1'b0);
        chk("rerun_run_bound", r_tmo, 0);
        chk("rerun_enables", r_en, 3);
        chk("rerun_done_count", r_done, 1);
        chk("rerun_done_latency", r_lat, 15);
        chk("rerun_pc_sequence_bad", r_pc_bad, 0);
        chk("rerun_instr_at_enable_bad", r_ins_bad, 0);
        chk("rerun_pc_at_done", r_pc_done, 3);
        chk("rerun_error_at_done", r_err_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clp_inst_dispatch
`default_nettype wire
